// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the frame-buffer / VGA slice.
//   H_ACTIVE, V_ACTIVE : visible raster size (columns, rows)
//   ROW_W, COL_W       : widths of the VRAM row / column addresses
//   DW                 : pixel width (4 bits each of R, G, B)
//   fill_state_t       : states of the rectangle-fill engine
//   pixel_t            : packed 12-bit RGB pixel
//   clip_col/clip_row  : unsigned min() helpers used when clipping rectangles
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;
  localparam int DW       = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  // Unsigned minimum at full column width.
  function automatic logic [COL_W-1:0] clip_col(input logic [COL_W-1:0] x,
                                                input logic [COL_W-1:0] lim);
    return (x > lim) ? lim : x;
  endfunction

  // Unsigned minimum at full row width.
  function automatic logic [ROW_W-1:0] clip_row(input logic [ROW_W-1:0] y,
                                                input logic [ROW_W-1:0] lim);
    return (y > lim) ? lim : y;
  endfunction

endpackage

// File: rtl/vram_raster_cnt.sv
// -----------------------------------------------------------------------------
// vram_raster_cnt
// Two-dimensional row/column counter walking a rectangle in raster order.
//   clk, rst       : clock, asynchronous active-high reset
//   load           : start a new rectangle at (x0, y0)
//   advance        : a pixel was transferred; step to the next position
//   x0             : left column, reused as the column on every row wrap
//   y0             : top row
//   x_end, y_end   : inclusive, already-clipped right column / bottom row
//   row, col       : current write address
//   last           : current position is the final pixel of the rectangle
// The counters only ever move between the loaded start and the bounds, so
// they never wrap and never exceed the clipped limits.
// -----------------------------------------------------------------------------
module vram_raster_cnt
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [COL_W-1:0] x0,
  input  logic [ROW_W-1:0] y0,
  input  logic [COL_W-1:0] x_end,
  input  logic [ROW_W-1:0] y_end,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic row_end;
  logic col_end;

  assign col_end = (col == x_end);
  assign row_end = (row == y_end);
  assign last    = col_end && row_end;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= y0;
      col <= x0;
    end else if (advance) begin
      if (!col_end) begin
        col <= col + COL_W'(1);
      end else if (!row_end) begin
        col <= x0;
        row <= row + ROW_W'(1);
      end
      // On the last pixel the position simply holds; the FSM leaves FILL.
    end
  end

endmodule

// File: rtl/vram_rect_fill.sv
// -----------------------------------------------------------------------------
// vram_rect_fill
// Rectangle-fill engine feeding the VRAM write port. A command (inclusive
// corners plus colour) is validated, clipped to the visible area and then
// written one pixel per transfer in raster order.
//   clk, rst        : pixel clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake; cmd_ready is registered, high in IDLE
//   cmd_x0, cmd_y0  : top-left corner
//   cmd_x1, cmd_y1  : bottom-right corner, inclusive
//   cmd_color       : fill colour
//   wr_en/wr_ready  : VRAM write request / arbiter acceptance
//   wr_row, wr_col  : registered write address
//   wr_data         : registered write pixel (latched colour)
//   busy            : engine not idle
//   done            : one-cycle pulse when the last pixel has been written
//   err             : one-cycle pulse when a command is rejected
// -----------------------------------------------------------------------------
module vram_rect_fill
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int DW       = vga_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [COL_W-1:0] cmd_x0,
  input  logic [ROW_W-1:0] cmd_y0,
  input  logic [COL_W-1:0] cmd_x1,
  input  logic [ROW_W-1:0] cmd_y1,
  input  logic [DW-1:0]    cmd_color,
  output logic             wr_en,
  input  logic             wr_ready,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [DW-1:0]    wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Limits expressed at port width so every comparison is unsigned and
  // full-width.
  localparam logic [COL_W-1:0] X_LIM  = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0] Y_LIM  = ROW_W'(V_ACTIVE);
  localparam logic [COL_W-1:0] X_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(V_ACTIVE - 1);

  fill_state_t state;
  fill_state_t state_next;

  // Latched command.
  logic [COL_W-1:0] x0_q;
  logic [COL_W-1:0] x1_q;
  logic [ROW_W-1:0] y0_q;
  logic [ROW_W-1:0] y1_q;
  logic [DW-1:0]    color_q;

  // Clipped inclusive bounds, valid from the first FILL cycle on.
  logic [COL_W-1:0] x1c_q;
  logic [ROW_W-1:0] y1c_q;

  logic accept;
  logic reject;
  logic load;
  logic advance;
  logic last;

  assign accept = cmd_valid && cmd_ready;

  // x1/y1 beyond the screen are legal (they get clipped); only an inverted
  // rectangle or a start point off-screen is refused.
  assign reject = (x0_q > x1_q) || (y0_q > y1_q) ||
                  (x0_q >= X_LIM) || (y0_q >= Y_LIM);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-cycle strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    err        = 1'b0;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (reject) begin
          err        = 1'b1;
          state_next = IDLE;
        end else begin
          load       = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (wr_ready) begin
          advance = 1'b1;
          if (last) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // cmd_ready is registered from the next state: it comes up one edge after
  // reset releases, drops right after an accept, and returns the cycle after
  // DONE or after a rejecting CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b0;
    end else begin
      cmd_ready <= (state_next == IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Command capture and clipping
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset as well so that wr_data and the
  // address outputs read zero while rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (accept) begin
      x0_q    <= cmd_x0;
      x1_q    <= cmd_x1;
      y0_q    <= cmd_y0;
      y1_q    <= cmd_y1;
      color_q <= cmd_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1c_q <= '0;
      y1c_q <= '0;
    end else if (load) begin
      x1c_q <= clip_col(x1_q, X_LAST);
      y1c_q <= clip_row(y1_q, Y_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Raster walker
  // ---------------------------------------------------------------------------
  vram_raster_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .x0      (x0_q),
    .y0      (y0_q),
    .x_end   (x1c_q),
    .y_end   (y1c_q),
    .row     (wr_row),
    .col     (wr_col),
    .last    (last)
  );

  // wr_en is decoded straight from the state flop so an asynchronous reset
  // removes the write request immediately.
  assign wr_en   = (state == FILL);
  assign busy    = (state != IDLE);
  assign wr_data = color_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_vram_rect_fill
// Directed bench for vram_rect_fill. A negedge monitor logs every transfer,
// wr_en cycle, done/err pulse and the cycle cmd_ready returns; each test then
// compares the log against hand-derived values. Cycle numbering: the cycle
// after accept edge T is "T+1", which the bench tracks as t0 + 1.
// -----------------------------------------------------------------------------
module tb_vram_rect_fill;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0;
  logic [8:0]  cmd_y0;
  logic [9:0]  cmd_x1;
  logic [8:0]  cmd_y1;
  logic [11:0] cmd_color;
  logic        wr_en;
  logic        wr_ready;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Monitor log, cleared at each command.
  logic [30:0] xfers[$];
  int en_cycles, first_en, last_en;
  int done_cnt, done_cyc, err_cnt, err_cyc;
  int ready_rise, max_row, max_col;
  int e_acc, t0;
  bit alt_mode, armed;

  vram_rect_fill dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    xfers.delete();
    en_cycles  = 0;
    first_en   = -1;
    last_en    = -1;
    done_cnt   = 0;
    done_cyc   = -1;
    err_cnt    = 0;
    err_cyc    = -1;
    ready_rise = -1;
    max_row    = -1;
    max_col    = -1;
    armed      = 1'b0;
  endtask

  // Monitor and wr_ready driver. In alternating mode wr_ready is 1 on the
  // first wr_en cycle of a fill, 0 on the next, and so on.
  initial begin
    logic        ready_now;
    bit          prev_stall;
    logic [30:0] prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    wr_ready   = 1'b1;
    forever begin
      @(negedge clk);
      ready_now = 1'b1;
      if (wr_en) begin
        ready_now = !alt_mode || (en_cycles % 2 == 0);
        if (en_cycles == 0) first_en = cyc;
        last_en = cyc;
        en_cycles++;
        if (prev_stall) check("hold_during_stall", {wr_row, wr_col, wr_data}, prev_word);
        if (int'(wr_row) > max_row) max_row = int'(wr_row);
        if (int'(wr_col) > max_col) max_col = int'(wr_col);
      end
      wr_ready = ready_now;
      if (wr_en && ready_now) xfers.push_back({wr_row, wr_col, wr_data});
      prev_stall = wr_en && !ready_now;
      prev_word  = {wr_row, wr_col, wr_data};
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if (armed && cmd_ready && ready_rise < 0 && cyc > e_acc) ready_rise = cyc;
    end
  end

  // Offer one command; returns in cycle T+2. During cycle T+1 (cmd_ready=0)
  // cmd_valid stays high with unrelated fields, which must be ignored.
  task automatic send_cmd(input logic [9:0] x0, input logic [8:0] y0,
                          input logic [9:0] x1, input logic [8:0] y1,
                          input logic [11:0] color, input bit alt);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("cmd_ready_before_cmd", cmd_ready, 1);
    clear_log();
    alt_mode  = alt;
    cmd_valid = 1'b1;
    cmd_x0    = x0;
    cmd_y0    = y0;
    cmd_x1    = x1;
    cmd_y1    = y1;
    cmd_color = color;
    @(posedge clk); #1;
    e_acc = cyc;
    t0    = e_acc - 1;
    armed = 1'b1;
    cmd_x0    = 10'd0;
    cmd_y0    = 9'd0;
    cmd_x1    = 10'd639;
    cmd_y1    = 9'd479;
    cmd_color = 12'hABC;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready_rise < 0 && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("ready_return_in_budget", ready_rise >= 0, 1);
  endtask

  task automatic check_xfers(input int x0, input int y0, input int x1c, input int y1c,
                             input logic [11:0] color);
    int i;
    i = 0;
    check("xfer_count", xfers.size(), (x1c - x0 + 1) * (y1c - y0 + 1));
    for (int r = y0; r <= y1c; r++) begin
      for (int c = x0; c <= x1c; c++) begin
        if (i < xfers.size())
          check($sformatf("xfer%0d", i), xfers[i], {9'(r), 10'(c), color});
        i++;
      end
    end
  endtask

  task automatic single_pixel_test();
    send_cmd(10'd5, 9'd7, 10'd5, 9'd7, 12'h00F, 1'b0);
    wait_ready();
    check("sp_en_cycles", en_cycles, 1);
    check("sp_first_en", first_en, t0 + 2);
    check_xfers(5, 7, 5, 7, 12'h00F);
    check("sp_done_cnt", done_cnt, 1);
    check("sp_done_cyc", done_cyc, t0 + 3);
    check("sp_ready_cyc", ready_rise, t0 + 4);
    check("sp_err_cnt", err_cnt, 0);
  endtask

  task automatic reject_test(input logic [9:0] x0, input logic [8:0] y0,
                             input logic [9:0] x1, input logic [8:0] y1);
    send_cmd(x0, y0, x1, y1, 12'h555, 1'b0);
    wait_ready();
    check("rej_err_cnt", err_cnt, 1);
    check("rej_err_cyc", err_cyc, t0 + 1);
    check("rej_en_cycles", en_cycles, 0);
    check("rej_done_cnt", done_cnt, 0);
    check("rej_ready_cyc", ready_rise, t0 + 2);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    cmd_color = '0;
    alt_mode  = 1'b0;
    clear_log();
    e_acc = 0;
    t0    = 0;
    #1 rst = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wr_row", wr_row, 0);
    check("rst_wr_col", wr_col, 0);
    check("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    #1 check("ready_low_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("ready_first_edge", cmd_ready, 1);

    // Single pixel.
    single_pixel_test();

    // 4x2 rectangle, no backpressure.
    send_cmd(10'd10, 9'd20, 10'd13, 9'd21, 12'hF00, 1'b0);
    wait_ready();
    check("r42_en_cycles", en_cycles, 8);
    check("r42_first_en", first_en, t0 + 2);
    check("r42_last_en", last_en, t0 + 9);
    check_xfers(10, 20, 13, 21, 12'hF00);
    check("r42_done_cyc", done_cyc, t0 + 10);
    check("r42_done_cnt", done_cnt, 1);
    check("r42_ready_cyc", ready_rise, t0 + 11);
    check("r42_err_cnt", err_cnt, 0);

    // Same rectangle, wr_ready alternating 1,0,...
    send_cmd(10'd10, 9'd20, 10'd13, 9'd21, 12'hF00, 1'b1);
    wait_ready();
    check("bp_en_cycles", en_cycles, 15);
    check("bp_first_en", first_en, t0 + 2);
    check("bp_last_en", last_en, t0 + 16);
    check_xfers(10, 20, 13, 21, 12'hF00);
    check("bp_done_cyc", done_cyc, t0 + 17);
    check("bp_done_cnt", done_cnt, 1);

    // Clipping at the bottom-right corner.
    send_cmd(10'd630, 9'd470, 10'd700, 9'd500, 12'h0F0, 1'b0);
    wait_ready();
    check("clip_en_cycles", en_cycles, 100);
    check_xfers(630, 470, 639, 479, 12'h0F0);
    check("clip_max_row", max_row, 479);
    check("clip_max_col", max_col, 639);
    check("clip_done_cyc", done_cyc, t0 + 102);
    check("clip_err_cnt", err_cnt, 0);

    // Rejects.
    reject_test(10'd20, 9'd0, 10'd10, 9'd0);
    reject_test(10'd640, 9'd0, 10'd650, 9'd5);
    reject_test(10'd0, 9'd480, 10'd3, 9'd481);

    // Reset after three transfers of a 4x2 fill.
    send_cmd(10'd10, 9'd20, 10'd13, 9'd21, 12'h0F0, 1'b0);
    n = 0;
    while (xfers.size() < 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_three_logged", xfers.size(), 3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid_wr_en", wr_en, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("mid_ready_low_before_edge", cmd_ready, 0);
    @(posedge clk); #1;
    check("mid_ready_first_edge", cmd_ready, 1);
    check("mid_xfer_total", xfers.size(), 3);
    check("mid_done_cnt", done_cnt, 0);
    check("mid_err_cnt", err_cnt, 0);
    single_pixel_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
